// File: rtl/dma_rd_arb_if.sv
// Bundle of requester-side and DMA-side handshake signals for the read-DMA arbiter.
// The slave modport is the arbiter's view; master is the requesters + DMA engine view.
interface dma_rd_arb_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 20,
  parameter int DATA_W = 512
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*LEN_W-1:0]  req_len;
  logic [DATA_W-1:0]       req_tdata;
  logic [N_REQ-1:0]        req_tvalid;
  logic [N_REQ-1:0]        req_tready;
  logic                    req_tlast;
  logic [N_REQ-1:0]        req_done;
  logic [ADDR_W-1:0]       dma_rd_desc_addr;
  logic [LEN_W-1:0]        dma_rd_desc_len;
  logic                    dma_rd_desc_valid;
  logic                    dma_rd_desc_ready;
  logic [DATA_W-1:0]       dma_rd_read_data_tdata;
  logic                    dma_rd_read_data_tvalid;
  logic                    dma_rd_read_data_tlast;
  logic                    dma_rd_read_data_tready;

  modport slave (
    input  req_valid, req_addr, req_len, req_tready,
    input  dma_rd_desc_ready, dma_rd_read_data_tdata, dma_rd_read_data_tvalid, dma_rd_read_data_tlast,
    output req_ready, req_tdata, req_tvalid, req_tlast, req_done,
    output dma_rd_desc_addr, dma_rd_desc_len, dma_rd_desc_valid, dma_rd_read_data_tready
  );

  modport master (
    output req_valid, req_addr, req_len, req_tready,
    output dma_rd_desc_ready, dma_rd_read_data_tdata, dma_rd_read_data_tvalid, dma_rd_read_data_tlast,
    input  req_ready, req_tdata, req_tvalid, req_tlast, req_done,
    input  dma_rd_desc_addr, dma_rd_desc_len, dma_rd_desc_valid, dma_rd_read_data_tready
  );
endinterface

// File: rtl/dma_rd_arb.sv
// Round-robin arbiter sharing one DDR read-DMA channel (descriptor + AXIS stream) among N_REQ
// requesters; one transfer in flight, stream routed to the granted requester until tlast.
module dma_rd_arb #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 20,
  parameter int DATA_W = 512
) (
  input  logic       clk,
  input  logic       rst,
  dma_rd_arb_if.slave bus
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DATA  = 2'd2
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [PTR_W-1:0]    rr_ptr_r, grant_r, pick_s;
  logic [PTR_W:0]      pick_res_s;
  logic                hit_s, accept_s, tready_s, last_hs_s;
  logic [ADDR_W-1:0]   desc_addr_r, pick_addr_s;
  logic [LEN_W-1:0]    desc_len_r, pick_len_s;
  logic [N_REQ-1:0]    done_r;

  // Round-robin search: first valid requester at or after ptr, modulo N_REQ.
  function automatic logic [PTR_W:0] rr_pick(input logic [N_REQ-1:0] vld, input logic [PTR_W-1:0] ptr);
    logic [PTR_W:0] res;
    int             idx;
    res = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (vld[idx]) begin
        res = {1'b1, PTR_W'(idx)};
      end
    end
    return res;
  endfunction

  assign pick_res_s  = rr_pick(bus.req_valid, rr_ptr_r);
  assign hit_s       = pick_res_s[PTR_W];
  assign pick_s      = pick_res_s[PTR_W-1:0];
  assign pick_addr_s = bus.req_addr[int'(pick_s)*ADDR_W +: ADDR_W];
  assign pick_len_s  = bus.req_len[int'(pick_s)*LEN_W +: LEN_W];
  // No grant during the reset cycle, since none of the grant state would be captured.
  assign accept_s    = (state_r == ST_IDLE) && hit_s && !rst;
  assign tready_s    = bus.req_tready[grant_r];
  assign last_hs_s   = (state_r == ST_DATA) && bus.dma_rd_read_data_tvalid && tready_s &&
                       bus.dma_rd_read_data_tlast;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && (pick_len_s != {LEN_W{1'b0}})) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (bus.dma_rd_desc_ready) begin
          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_DATA: begin
        if (last_hs_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Grant, round-robin pointer, latched descriptor and done pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r    <= {PTR_W{1'b0}};
      grant_r     <= {PTR_W{1'b0}};
      desc_addr_r <= {ADDR_W{1'b0}};
      desc_len_r  <= {LEN_W{1'b0}};
      done_r      <= {N_REQ{1'b0}};
    end else begin
      done_r <= {N_REQ{1'b0}};
      if (accept_s) begin
        grant_r     <= pick_s;
        desc_addr_r <= pick_addr_s;
        desc_len_r  <= pick_len_s;
        rr_ptr_r    <= (pick_s == PTR_W'(N_REQ - 1)) ? {PTR_W{1'b0}} : pick_s + PTR_W'(1);
        // A zero-length descriptor is retired immediately without touching the DMA.
        if (pick_len_s == {LEN_W{1'b0}}) begin
          done_r[pick_s] <= 1'b1;
        end
      end
      if (last_hs_s) begin
        done_r[grant_r] <= 1'b1;
      end
    end
  end

  assign bus.dma_rd_desc_addr = desc_addr_r;
  assign bus.dma_rd_desc_len  = desc_len_r;
  assign bus.req_done         = done_r;

  // Output decode: accept pulse, descriptor valid and zero-latency stream routing.
  always_comb begin
    bus.req_ready               = {N_REQ{1'b0}};
    bus.req_tvalid              = {N_REQ{1'b0}};
    bus.req_tdata               = {DATA_W{1'b0}};
    bus.req_tlast               = 1'b0;
    bus.dma_rd_desc_valid       = 1'b0;
    bus.dma_rd_read_data_tready = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          bus.req_ready[pick_s] = 1'b1;
        end else begin
          bus.req_ready = {N_REQ{1'b0}};
        end
      end
      ST_ISSUE: begin
        bus.dma_rd_desc_valid = 1'b1;
      end
      ST_DATA: begin
        bus.req_tvalid[grant_r]     = bus.dma_rd_read_data_tvalid;
        bus.dma_rd_read_data_tready = tready_s;
        bus.req_tdata               = bus.dma_rd_read_data_tdata;
        bus.req_tlast               = bus.dma_rd_read_data_tlast;
      end
      default: begin
        bus.req_ready = {N_REQ{1'b0}};
      end
    endcase
  end
endmodule

// File: tb/tb_dma_rd_arb.sv
// Directed self-checking bench for dma_rd_arb: a 2-requester instance for most scenarios and a
// 4-requester instance for the pointer-wrap case.
module tb_dma_rd_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  dma_rd_arb_if #(.N_REQ(2), .ADDR_W(32), .LEN_W(20), .DATA_W(512)) b2 ();
  dma_rd_arb_if #(.N_REQ(4), .ADDR_W(32), .LEN_W(20), .DATA_W(512)) b4 ();

  dma_rd_arb #(.N_REQ(2), .ADDR_W(32), .LEN_W(20), .DATA_W(512)) u2 (.clk(clk), .rst(rst), .bus(b2));
  dma_rd_arb #(.N_REQ(4), .ADDR_W(32), .LEN_W(20), .DATA_W(512)) u4 (.clk(clk), .rst(rst), .bus(b4));

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    b2.req_valid = '0; b2.req_addr = '0; b2.req_len = '0; b2.req_tready = '0;
    b2.dma_rd_desc_ready = 1'b0; b2.dma_rd_read_data_tdata = '0;
    b2.dma_rd_read_data_tvalid = 1'b0; b2.dma_rd_read_data_tlast = 1'b0;
    b4.req_valid = '0; b4.req_addr = '0; b4.req_len = '0; b4.req_tready = '0;
    b4.dma_rd_desc_ready = 1'b0; b4.dma_rd_read_data_tdata = '0;
    b4.dma_rd_read_data_tvalid = 1'b0; b4.dma_rd_read_data_tlast = 1'b0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  // One 2-beat transfer on the 2-requester DUT; starts in an IDLE cycle with req_valid set up.
  task automatic run_xfer(input logic [1:0] gnt, input logic [31:0] exp_addr, input logic [19:0] exp_len);
    #1;
    n_checks++; if (b2.req_ready !== gnt) begin n_fail++; $display("FAIL xfer_ready: got %b expected %b", b2.req_ready, gnt); end
    cyc();
    b2.dma_rd_desc_ready = 1'b1;
    #1;
    n_checks++; if (b2.dma_rd_desc_valid !== 1'b1) begin n_fail++; $display("FAIL xfer_desc_valid: got %b expected 1", b2.dma_rd_desc_valid); end
    n_checks++; if (b2.dma_rd_desc_addr !== exp_addr) begin n_fail++; $display("FAIL xfer_addr: got %h expected %h", b2.dma_rd_desc_addr, exp_addr); end
    n_checks++; if (b2.dma_rd_desc_len !== exp_len) begin n_fail++; $display("FAIL xfer_len: got %0d expected %0d", b2.dma_rd_desc_len, exp_len); end
    n_checks++; if (b2.req_ready !== 2'b00) begin n_fail++; $display("FAIL xfer_ready_issue: got %b expected 00", b2.req_ready); end
    cyc();
    b2.dma_rd_desc_ready = 1'b0;
    b2.req_tready = 2'b11;
    for (int b = 0; b < 2; b++) begin
      b2.dma_rd_read_data_tvalid = 1'b1;
      b2.dma_rd_read_data_tdata  = 512'(32'hA0 + b);
      b2.dma_rd_read_data_tlast  = (b == 1);
      #1;
      n_checks++; if (b2.req_tvalid !== gnt) begin n_fail++; $display("FAIL xfer_tvalid: got %b expected %b", b2.req_tvalid, gnt); end
      cyc();
    end
    b2.dma_rd_read_data_tvalid = 1'b0;
    b2.dma_rd_read_data_tlast  = 1'b0;
    b2.req_tready = 2'b00;
    #1;
    n_checks++; if (b2.req_done !== gnt) begin n_fail++; $display("FAIL xfer_done: got %b expected %b", b2.req_done, gnt); end
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    n_checks++; if (b2.dma_rd_desc_valid !== 1'b0) begin n_fail++; $display("FAIL rst_desc_valid: got %b expected 0", b2.dma_rd_desc_valid); end
    n_checks++; if (b2.req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_req_ready: got %b expected 00", b2.req_ready); end
    n_checks++; if (b2.req_done !== 2'b00) begin n_fail++; $display("FAIL rst_req_done: got %b expected 00", b2.req_done); end
    n_checks++; if (b2.req_tvalid !== 2'b00) begin n_fail++; $display("FAIL rst_tvalid: got %b expected 00", b2.req_tvalid); end
    n_checks++; if (b2.dma_rd_read_data_tready !== 1'b0) begin n_fail++; $display("FAIL rst_tready: got %b expected 0", b2.dma_rd_read_data_tready); end
    n_checks++; if (b2.dma_rd_desc_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h expected 0", b2.dma_rd_desc_addr); end
  endtask

  task automatic test_single;
    int hold;
    do_reset();
    b2.req_valid = 2'b01; b2.req_addr[31:0] = 32'h1000; b2.req_len[19:0] = 20'd256;
    #1;
    n_checks++; if (b2.req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b expected 01", b2.req_ready); end
    cyc();
    b2.req_valid = 2'b00;
    hold = 0;
    for (int c = 0; c < 4; c++) begin
      b2.dma_rd_desc_ready = (c == 3);
      #1;
      if (b2.dma_rd_desc_valid === 1'b1) hold++;
      n_checks++; if (b2.dma_rd_desc_addr !== 32'h1000) begin n_fail++; $display("FAIL single_addr: got %h expected 1000", b2.dma_rd_desc_addr); end
      cyc();
    end
    b2.dma_rd_desc_ready = 1'b0;
    #1;
    n_checks++; if (hold !== 4) begin n_fail++; $display("FAIL single_desc_hold: got %0d expected 4", hold); end
    n_checks++; if (b2.dma_rd_desc_valid !== 1'b0) begin n_fail++; $display("FAIL single_desc_drop: got %b expected 0", b2.dma_rd_desc_valid); end
    b2.req_tready = 2'b01;
    for (int b = 0; b < 4; b++) begin
      b2.dma_rd_read_data_tvalid = 1'b1;
      b2.dma_rd_read_data_tdata  = 512'(32'h100 + b);
      b2.dma_rd_read_data_tlast  = (b == 3);
      #1;
      n_checks++; if (b2.req_tvalid !== 2'b01) begin n_fail++; $display("FAIL single_tvalid: got %b expected 01", b2.req_tvalid); end
      n_checks++; if (b2.dma_rd_read_data_tready !== 1'b1) begin n_fail++; $display("FAIL single_tready: got %b expected 1", b2.dma_rd_read_data_tready); end
      n_checks++; if (b2.req_tdata[31:0] !== 32'h100 + b) begin n_fail++; $display("FAIL single_tdata: got %h expected %h", b2.req_tdata[31:0], 32'h100 + b); end
      n_checks++; if (b2.req_done !== 2'b00) begin n_fail++; $display("FAIL single_done_early: got %b expected 00", b2.req_done); end
      cyc();
    end
    b2.dma_rd_read_data_tvalid = 1'b0; b2.dma_rd_read_data_tlast = 1'b0; b2.req_tready = 2'b00;
    #1;
    n_checks++; if (b2.req_done !== 2'b01) begin n_fail++; $display("FAIL single_done: got %b expected 01", b2.req_done); end
    n_checks++; if (b2.req_tvalid !== 2'b00) begin n_fail++; $display("FAIL single_idle_tvalid: got %b expected 00", b2.req_tvalid); end
    cyc();
    n_checks++; if (b2.req_done !== 2'b00) begin n_fail++; $display("FAIL single_done_width: got %b expected 00", b2.req_done); end
  endtask

  task automatic test_round_robin;
    do_reset();
    b2.req_valid = 2'b11;
    b2.req_addr  = {32'h2000, 32'h1000};
    b2.req_len   = {20'd64, 20'd64};
    run_xfer(2'b01, 32'h1000, 20'd64);
    run_xfer(2'b10, 32'h2000, 20'd64);
    run_xfer(2'b01, 32'h1000, 20'd64);
    run_xfer(2'b10, 32'h2000, 20'd64);
    b2.req_valid = 2'b00;
    cyc();
  endtask

  task automatic test_backpressure;
    int   rcv, c;
    logic pat, fin;
    do_reset();
    b2.req_valid = 2'b01; b2.req_addr[31:0] = 32'h5000; b2.req_len[19:0] = 20'd512;
    cyc();
    b2.req_valid = 2'b00; b2.dma_rd_desc_ready = 1'b1;
    cyc();
    b2.dma_rd_desc_ready = 1'b0;
    rcv = 0; c = 0; fin = 1'b0;
    while (!fin && c < 40) begin
      pat = (c % 2 == 0);
      b2.req_tready = {1'b1, pat};
      b2.dma_rd_read_data_tvalid = 1'b1;
      b2.dma_rd_read_data_tdata  = 512'(1000 + rcv);
      b2.dma_rd_read_data_tlast  = (rcv == 7);
      #1;
      n_checks++; if (b2.dma_rd_read_data_tready !== pat) begin n_fail++; $display("FAIL bp_tready c%0d: got %b expected %b", c, b2.dma_rd_read_data_tready, pat); end
      n_checks++; if (b2.req_tvalid !== 2'b01) begin n_fail++; $display("FAIL bp_tvalid c%0d: got %b expected 01", c, b2.req_tvalid); end
      if (b2.dma_rd_read_data_tready === 1'b1) begin
        n_checks++; if (b2.req_tdata[31:0] !== 32'(1000 + rcv)) begin n_fail++; $display("FAIL bp_tdata: got %0d expected %0d", b2.req_tdata[31:0], 1000 + rcv); end
        rcv++;
        if (rcv == 8) fin = 1'b1;
      end
      cyc();
      c++;
    end
    b2.dma_rd_read_data_tvalid = 1'b0; b2.dma_rd_read_data_tlast = 1'b0; b2.req_tready = 2'b00;
    #1;
    n_checks++; if (rcv !== 8) begin n_fail++; $display("FAIL bp_beats: got %0d expected 8", rcv); end
    n_checks++; if (c !== 15) begin n_fail++; $display("FAIL bp_cycles: got %0d expected 15", c); end
    n_checks++; if (b2.req_done !== 2'b01) begin n_fail++; $display("FAIL bp_done: got %b expected 01", b2.req_done); end
  endtask

  task automatic test_zero_len;
    do_reset();
    b2.req_valid = 2'b10; b2.req_addr[63:32] = 32'h3000; b2.req_len[39:20] = 20'd0;
    #1;
    n_checks++; if (b2.req_ready !== 2'b10) begin n_fail++; $display("FAIL zl_ready: got %b expected 10", b2.req_ready); end
    cyc();
    b2.req_valid = 2'b00;
    #1;
    n_checks++; if (b2.req_done !== 2'b10) begin n_fail++; $display("FAIL zl_done: got %b expected 10", b2.req_done); end
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (b2.dma_rd_desc_valid !== 1'b0) begin n_fail++; $display("FAIL zl_desc_valid: got %b expected 0", b2.dma_rd_desc_valid); end
      cyc();
    end
    n_checks++; if (b2.req_done !== 2'b00) begin n_fail++; $display("FAIL zl_done_clear: got %b expected 00", b2.req_done); end
  endtask

  task automatic test_mid_reset;
    do_reset();
    b2.req_valid = 2'b01; b2.req_addr[31:0] = 32'h1000; b2.req_len[19:0] = 20'd256;
    cyc();
    b2.req_valid = 2'b00; b2.dma_rd_desc_ready = 1'b1;
    cyc();
    b2.dma_rd_desc_ready = 1'b0; b2.req_tready = 2'b01;
    b2.dma_rd_read_data_tvalid = 1'b1; b2.dma_rd_read_data_tdata = 512'(1);
    cyc();
    b2.dma_rd_read_data_tdata = 512'(2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    b2.dma_rd_read_data_tvalid = 1'b0; b2.req_tready = 2'b00;
    #1;
    n_checks++; if (b2.req_tvalid !== 2'b00) begin n_fail++; $display("FAIL mr_tvalid: got %b expected 00", b2.req_tvalid); end
    n_checks++; if (b2.dma_rd_read_data_tready !== 1'b0) begin n_fail++; $display("FAIL mr_tready: got %b expected 0", b2.dma_rd_read_data_tready); end
    n_checks++; if (b2.dma_rd_desc_valid !== 1'b0) begin n_fail++; $display("FAIL mr_desc_valid: got %b expected 0", b2.dma_rd_desc_valid); end
    n_checks++; if (b2.dma_rd_desc_addr !== 32'h0) begin n_fail++; $display("FAIL mr_addr: got %h expected 0", b2.dma_rd_desc_addr); end
    n_checks++; if (b2.dma_rd_desc_len !== 20'h0) begin n_fail++; $display("FAIL mr_len: got %h expected 0", b2.dma_rd_desc_len); end
    n_checks++; if (b2.req_done !== 2'b00) begin n_fail++; $display("FAIL mr_done: got %b expected 00", b2.req_done); end
    n_checks++; if (b2.req_ready !== 2'b00) begin n_fail++; $display("FAIL mr_ready: got %b expected 00", b2.req_ready); end
    b2.req_valid = 2'b01; b2.req_addr[31:0] = 32'h4000; b2.req_len[19:0] = 20'd64;
    run_xfer(2'b01, 32'h4000, 20'd64);
    b2.req_valid = 2'b00;
    cyc();
  endtask

  task automatic test_wrap4;
    do_reset();
    b4.req_valid = 4'b0001; b4.req_len[19:0] = 20'd0;
    #1;
    n_checks++; if (b4.req_ready !== 4'b0001) begin n_fail++; $display("FAIL w4_drop_ready: got %b expected 0001", b4.req_ready); end
    cyc();
    b4.req_valid = 4'b1000; b4.req_addr[127:96] = 32'h8000; b4.req_len[79:60] = 20'd128;
    #1;
    n_checks++; if (b4.req_ready !== 4'b1000) begin n_fail++; $display("FAIL w4_ready3: got %b expected 1000", b4.req_ready); end
    n_checks++; if (b4.req_done !== 4'b0001) begin n_fail++; $display("FAIL w4_drop_done: got %b expected 0001", b4.req_done); end
    cyc();
    b4.req_valid = 4'b0000; b4.dma_rd_desc_ready = 1'b1;
    #1;
    n_checks++; if (b4.dma_rd_desc_addr !== 32'h8000) begin n_fail++; $display("FAIL w4_addr: got %h expected 8000", b4.dma_rd_desc_addr); end
    cyc();
    b4.dma_rd_desc_ready = 1'b0; b4.req_tready = 4'b1000;
    b4.dma_rd_read_data_tvalid = 1'b1; b4.dma_rd_read_data_tlast = 1'b1;
    #1;
    n_checks++; if (b4.req_tvalid !== 4'b1000) begin n_fail++; $display("FAIL w4_tvalid: got %b expected 1000", b4.req_tvalid); end
    cyc();
    b4.dma_rd_read_data_tvalid = 1'b0; b4.dma_rd_read_data_tlast = 1'b0; b4.req_tready = 4'b0000;
    b4.req_valid = 4'b1001; b4.req_len[19:0] = 20'd32;
    #1;
    n_checks++; if (b4.req_done !== 4'b1000) begin n_fail++; $display("FAIL w4_done: got %b expected 1000", b4.req_done); end
    // Pointer must have wrapped to 0, so requester 0 beats requester 3.
    n_checks++; if (b4.req_ready !== 4'b0001) begin n_fail++; $display("FAIL w4_wrap: got %b expected 0001", b4.req_ready); end
    b4.req_valid = 4'b0000;
    cyc();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_zero_len();
    test_mid_reset();
    test_wrap4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
